// File: rtl/ir_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ir_fetch_ctrl_pkg
// Shared definitions for the instruction-register fetch controller:
//   - IR function-select encodings driven on ir_FunSel
//   - fetch FSM state encoding
//   - bus widths used by the controller, its interface and pc_counter
// ----------------------------------------------------------------------------
package ir_fetch_ctrl_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WAIT_W = 8;

  // IR function-select encodings understood by the IR register.
  typedef enum logic [1:0] {
    IR_CLEAR = 2'b00,
    IR_LOAD  = 2'b01,
    IR_DEC   = 2'b10,
    IR_INC   = 2'b11
  } ir_funsel_e;

  // Fetch FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    REQ_LO = 3'd2,
    REQ_HI = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } fetch_state_e;

  // True for the two states that hold a memory request open.
  function automatic logic is_req_state(input fetch_state_e st);
    logic res;
    case (st)
      REQ_LO, REQ_HI: res = 1'b1;
      default:        res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ir_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// ir_fetch_ctrl_if
// Memory-read handshake and IR-write bus between the fetch controller and
// the memory / IR register side.
//   mem_req, mem_addr          : byte read request and address (controller)
//   mem_data, mem_valid        : returned byte and its qualifier (memory)
//   ir_I, ir_FunSel, ir_LH,
//   ir_enable                  : IR write port (controller)
// Modports: master = controller, slave = memory / IR side.
// ----------------------------------------------------------------------------
interface ir_fetch_ctrl_if;
  import ir_fetch_ctrl_pkg::*;

  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic [DATA_W-1:0] ir_I;
  logic [1:0]        ir_FunSel;
  logic              ir_LH;
  logic              ir_enable;

  modport master (
    output mem_req, mem_addr, ir_I, ir_FunSel, ir_LH, ir_enable,
    input  mem_data, mem_valid
  );

  modport slave (
    input  mem_req, mem_addr, ir_I, ir_FunSel, ir_LH, ir_enable,
    output mem_data, mem_valid
  );

endinterface

// File: rtl/ir_fetch_ctrl_pc_counter.sv
// ----------------------------------------------------------------------------
// pc_counter
// 16-bit program counter with synchronous load and increment.
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset, clears pc to 0
//   load     : load pc from load_val (wins over inc)
//   inc      : pc <= pc + 1, modulo 2^16
//   load_val : value loaded when load is high
//   pc       : current program counter
// ----------------------------------------------------------------------------
module pc_counter
  import ir_fetch_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_r;

  // Program counter register; the add wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= '0;
    end else if (load) begin
      pc_r <= load_val;
    end else if (inc) begin
      pc_r <= pc_r + 16'd1;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/ir_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// ir_fetch_ctrl
// Fetches a 16-bit instruction as two byte reads (low byte at pc, high byte
// at pc+1) and writes them into the IR, after first clearing the IR.
// Each byte waits at most TIMEOUT cycles for mem_valid; on expiry the fetch
// is aborted with a one-cycle error pulse.
//   clock, reset : clock and synchronous active-high reset
//   start        : begin a fetch (only looked at in IDLE)
//   pc_load      : load pc from pc_in (only looked at in IDLE)
//   pc_in        : new program-counter value
//   bus          : memory handshake + IR write port (master side)
//   pc           : current program counter
//   busy         : high whenever not IDLE
//   done         : one-cycle pulse, instruction complete in IR
//   error        : one-cycle pulse, fetch aborted on timeout
// TIMEOUT must be in 1..255.
// ----------------------------------------------------------------------------
module ir_fetch_ctrl
  import ir_fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_in,
  ir_fetch_ctrl_if.master bus,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            error
);

  // Counter value seen in the last permitted waiting cycle of a byte.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              wait_clr_s;
  logic              wait_inc_s;
  logic              pc_ld_s;
  logic              pc_inc_s;
  logic              accept_s;
  logic              mem_req_s;
  logic              ir_en_s;
  ir_funsel_e        ir_funsel_s;
  logic              ir_lh_s;
  logic [DATA_W-1:0] ir_i_s;
  logic              busy_s;
  logic              done_s;
  logic              error_s;

  // A byte returned while reset is asserted is discarded so that a reset
  // in the middle of a fetch never produces an IR write.
  assign accept_s = bus.mem_valid & ~reset & is_req_state(state_r);

  pc_counter u_pc_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (pc_ld_s),
    .inc      (pc_inc_s),
    .load_val (pc_in),
    .pc       (pc)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Per-byte wait counter: cleared on entry to a request state, counts
  // request cycles that pass without mem_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (wait_clr_s) begin
      wait_cnt_r <= '0;
    end else if (wait_inc_s) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next_s = state_r;
    wait_clr_s   = 1'b0;
    wait_inc_s   = 1'b0;
    pc_ld_s      = 1'b0;
    pc_inc_s     = 1'b0;
    mem_req_s    = 1'b0;
    ir_en_s      = 1'b0;
    ir_funsel_s  = IR_CLEAR;
    ir_lh_s      = 1'b0;
    ir_i_s       = '0;
    busy_s       = 1'b1;
    done_s       = 1'b0;
    error_s      = 1'b0;

    case (state_r)
      IDLE: begin
        busy_s  = 1'b0;
        // pc_load and start together: pc is loaded on the same edge the
        // FSM leaves IDLE, so the fetch addresses the new pc.
        pc_ld_s = pc_load;
        if (start) begin
          state_next_s = CLR;
        end else begin
          state_next_s = IDLE;
        end
      end

      CLR: begin
        ir_en_s      = ~reset;
        ir_funsel_s  = IR_CLEAR;
        wait_clr_s   = 1'b1;
        state_next_s = REQ_LO;
      end

      REQ_LO, REQ_HI: begin
        mem_req_s = 1'b1;
        if (accept_s) begin
          ir_en_s     = 1'b1;
          ir_funsel_s = IR_LOAD;
          ir_lh_s     = (state_r == REQ_HI);
          ir_i_s      = bus.mem_data;
          pc_inc_s    = 1'b1;
          wait_clr_s  = 1'b1;
          if (state_r == REQ_LO) begin
            state_next_s = REQ_HI;
          end else begin
            state_next_s = DONE;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          // This was the TIMEOUT-th cycle without data: abort, pc untouched.
          state_next_s = ERR;
        end else begin
          wait_inc_s = 1'b1;
        end
      end

      DONE: begin
        done_s       = ~reset;
        state_next_s = IDLE;
      end

      ERR: begin
        error_s      = ~reset;
        state_next_s = IDLE;
      end

      default: begin
        busy_s       = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = mem_req_s;
  assign bus.mem_addr  = pc;
  assign bus.ir_enable = ir_en_s;
  assign bus.ir_FunSel = ir_funsel_s;
  assign bus.ir_LH     = ir_lh_s;
  assign bus.ir_I      = ir_i_s;
  assign busy          = busy_s;
  assign done          = done_s;
  assign error         = error_s;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ir_fetch_ctrl
// Self-checking bench for ir_fetch_ctrl (TIMEOUT = 4). Each fetch is
// described by the number of idle cycles before each byte arrives; the
// expected cycle-by-cycle outputs, final pc and IR contents are computed
// from those delays with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_ir_fetch_ctrl;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        pc_load;
  logic [15:0] pc_in;
  logic [15:0] pc;
  logic        busy;
  logic        done;
  logic        error;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] pc_m;     // expected pc while idle
  logic [15:0] ir_obs;   // IR image rebuilt from the DUT's IR write port

  ir_fetch_ctrl_if bus ();

  ir_fetch_ctrl #(.TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .pc_load (pc_load),
    .pc_in   (pc_in),
    .bus     (bus.master),
    .pc      (pc),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // One fetch: d_lo / d_hi are idle cycles before each byte (>= TO means
  // that byte never arrives). Entered and left just after a rising edge
  // with the DUT in IDLE.
  task automatic run_fetch(input int d_lo, input int d_hi,
                           input logic [7:0] lo, input logic [7:0] hi,
                           input bit do_load, input logic [15:0] load_val,
                           input bit noise);
    bit lo_ok, hi_ok, in_lo, in_hi, exp_req, exp_en, exp_lh;
    int t_lo, t_hi, last;
    logic [15:0] pc_start, exp_pc, exp_ir, obs, exp;
    logic [7:0]  exp_i;
    lo_ok    = (d_lo < TO);
    hi_ok    = (d_hi < TO);
    t_lo     = 2 + d_lo;
    t_hi     = t_lo + 1 + d_hi;
    last     = !lo_ok ? 2 + TO : (!hi_ok ? t_lo + 1 + TO : t_hi + 1);
    pc_start = do_load ? load_val : pc_m;
    ir_obs   = 16'hDEAD;
    for (int c = 0; c <= last; c++) begin
      start   = (c == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      pc_load = (c == 0) ? do_load : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      pc_in   = (c == 0) ? load_val : 16'($urandom);
      if (lo_ok && c == t_lo) begin
        bus.mem_valid = 1'b1; bus.mem_data = lo;
      end else if (lo_ok && hi_ok && c == t_hi) begin
        bus.mem_valid = 1'b1; bus.mem_data = hi;
      end else begin
        bus.mem_valid = (noise && (c == 1 || c == last)) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_data  = 8'($urandom);
      end
      in_lo   = (c >= 2) && (c <= (lo_ok ? t_lo : 1 + TO));
      in_hi   = lo_ok && (c > t_lo) && (c <= (hi_ok ? t_hi : t_lo + TO));
      exp_req = in_lo || in_hi;
      exp_en  = (c == 1) || (lo_ok && c == t_lo) || (lo_ok && hi_ok && c == t_hi);
      exp_lh  = lo_ok && hi_ok && (c == t_hi);
      exp_i   = (c == 1 || !exp_en) ? 8'h00 : (exp_lh ? hi : lo);
      exp_pc  = (c == 0) ? pc_m :
                pc_start + 16'(lo_ok && c > t_lo) + 16'(lo_ok && hi_ok && c > t_hi);
      exp = {(c > 0), (c == last) && lo_ok && hi_ok, (c == last) && !(lo_ok && hi_ok),
             exp_req, exp_en, 1'b0, (exp_en && c != 1), exp_lh, exp_i};
      @(negedge clock);
      obs = {busy, done, error, bus.mem_req, bus.ir_enable, bus.ir_FunSel, bus.ir_LH, bus.ir_I};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL ctl c=%0d d_lo=%0d d_hi=%0d got=%h exp=%h", c, d_lo, d_hi, obs, exp);
      end
      checks++;
      if ({pc, bus.mem_addr} !== {exp_pc, exp_pc}) begin
        failures++;
        $display("FAIL pc c=%0d got pc=%h addr=%h exp=%h", c, pc, bus.mem_addr, exp_pc);
      end
      if (bus.ir_enable === 1'b1) begin
        case (bus.ir_FunSel)
          2'b00:   ir_obs = 16'h0000;
          2'b01:   if (bus.ir_LH) ir_obs[15:8] = bus.ir_I; else ir_obs[7:0] = bus.ir_I;
          default: ir_obs = 16'hBAD0;
        endcase
      end
      @(posedge clock); #1;
    end
    start = 1'b0; pc_load = 1'b0; bus.mem_valid = 1'b0;
    pc_m   = pc_start + 16'(lo_ok) + 16'(lo_ok && hi_ok);
    exp_ir = !lo_ok ? 16'h0000 : (hi_ok ? {hi, lo} : {8'h00, lo});
    checks++;
    if (ir_obs !== exp_ir) begin
      failures++;
      $display("FAIL ir_image d_lo=%0d d_hi=%0d got=%h exp=%h", d_lo, d_hi, ir_obs, exp_ir);
    end
  endtask

  // Idle cycles with no request: nothing may start on its own.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; pc_load = 1'b0; bus.mem_valid = 1'($urandom_range(0, 1));
      @(negedge clock);
      checks++;
      if ({busy, done, error, bus.mem_req, bus.ir_enable, pc} !== {5'b00000, pc_m}) begin
        failures++;
        $display("FAIL idle busy=%b done=%b err=%b req=%b en=%b pc=%h exp_pc=%h",
                 busy, done, error, bus.mem_req, bus.ir_enable, pc, pc_m);
      end
      @(posedge clock); #1;
    end
    bus.mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; pc_load = 1'b1; pc_in = 16'hABCD;
    bus.mem_valid = 1'b1; bus.mem_data = 8'h5A;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; start = 1'b0; pc_load = 1'b0; bus.mem_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, done, error, bus.mem_req, bus.ir_enable, bus.ir_FunSel, bus.ir_LH, bus.ir_I,
         pc, bus.mem_addr} !== 48'h0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b err=%b req=%b en=%b pc=%h addr=%h",
               busy, done, error, bus.mem_req, bus.ir_enable, pc, bus.mem_addr);
    end
    @(posedge clock); #1;
    pc_m = 16'h0000;
  endtask

  task automatic test_basic();
    run_fetch(0, 0, 8'h34, 8'h12, 1'b1, 16'h0100, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_delayed();
    run_fetch(3, 3, 8'hA5, 8'h5A, 1'b0, 16'h0000, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_timeout();
    run_fetch(TO + 2, 0, 8'h11, 8'h22, 1'b1, 16'h0400, 1'b0);
    idle_cycles(1);
    run_fetch(1, TO, 8'hC3, 8'h3C, 1'b0, 16'h0000, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_wrap();
    run_fetch(0, 0, 8'hEF, 8'hBE, 1'b1, 16'hFFFF, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    run_fetch(0, 1, 8'h01, 8'h02, 1'b1, 16'h2000, 1'b0);
    run_fetch(2, 0, 8'h03, 8'h04, 1'b0, 16'h0000, 1'b0);
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_fetch();
    start = 1'b1; pc_load = 1'b1; pc_in = 16'h0200;
    @(negedge clock);
    @(posedge clock); #1;
    start = 1'b0; pc_load = 1'b0;
    @(posedge clock); #1;                        // CLR
    bus.mem_valid = 1'b1; bus.mem_data = 8'h77;  // low byte
    @(negedge clock);
    checks++;
    if ({bus.ir_enable, bus.ir_LH, bus.ir_I} !== {1'b1, 1'b0, 8'h77}) begin
      failures++;
      $display("FAIL mid_lo got en=%b lh=%b I=%h exp en=1 lh=0 I=77",
               bus.ir_enable, bus.ir_LH, bus.ir_I);
    end
    @(posedge clock); #1;                        // REQ_HI: reset with noise
    reset = 1'b1; start = 1'b1; pc_load = 1'b1; pc_in = 16'h5555;
    bus.mem_valid = 1'b1; bus.mem_data = 8'h99;
    @(negedge clock);
    checks++;
    if ({bus.ir_enable, done, error, pc} !== {3'b000, 16'h0201}) begin
      failures++;
      $display("FAIL mid_reset got en=%b done=%b err=%b pc=%h exp en=0 done=0 err=0 pc=0201",
               bus.ir_enable, done, error, pc);
    end
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0; pc_load = 1'b0; bus.mem_valid = 1'b0;
    pc_m = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if ({busy, done, error, bus.ir_enable, pc} !== {4'b0000, 16'h0000}) begin
        failures++;
        $display("FAIL post_reset i=%0d busy=%b done=%b err=%b en=%b pc=%h exp all 0",
                 i, busy, done, error, bus.ir_enable, pc);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_fetch($urandom_range(0, 5), $urandom_range(0, 5), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc_load = 1'b0; pc_in = 16'h0000;
    bus.mem_valid = 1'b0; bus.mem_data = 8'h00;
    pc_m = 16'h0000; ir_obs = 16'h0000;
    test_reset();
    test_basic();
    test_delayed();
    test_timeout();
    test_wrap();
    test_back_to_back();
    test_reset_mid_fetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_fetch_ctrl.md
IR_FETCH_CTRL -- requirements
Module: ir_fetch_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles waited per byte for mem_valid (range 1..255).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous input is used.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  fetch request, sampled only in IDLE.
REQ-006 pc_load  in  1  load pc from pc_in, honoured only in IDLE.
REQ-007 pc_in  in  16  new program-counter value.
REQ-008 mem_data  in  8  byte returned by memory.
REQ-009 mem_valid  in  1  mem_data valid this cycle.
REQ-010 mem_req  out  1  byte read request, held until mem_valid or timeout.
REQ-011 mem_addr  out  16  byte address, equals pc.
REQ-012 ir_I  out  8  byte to IR register.
REQ-013 ir_FunSel  out  2  IR function: 00 clear, 01 load.
REQ-014 ir_LH  out  1  IR half select: 0 low byte, 1 high byte.
REQ-015 ir_enable  out  1  IR write enable.
REQ-016 pc  out  16  current program counter.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse: instruction complete in IR.
REQ-019 error  out  1  one-cycle pulse: fetch aborted on timeout.

Function
REQ-020 FSM states SHALL be IDLE, CLR, REQ_LO, REQ_HI, DONE, ERR.
REQ-021 IDLE: start=1 -> CLR; pc_load=1 -> pc<=pc_in; both set in one cycle -> pc loaded and CLR entered, fetch uses the new pc.
REQ-022 CLR: one cycle, ir_enable=1, ir_FunSel=00; -> REQ_LO.
REQ-023 REQ_LO/REQ_HI: mem_req=1, mem_addr=pc; ir_enable=0 until mem_valid.
REQ-024 On mem_valid in REQ_LO: same cycle ir_I=mem_data, ir_FunSel=01, ir_LH=0, ir_enable=1; pc<=pc+1; -> REQ_HI.
REQ-025 On mem_valid in REQ_HI: same cycle ir_I=mem_data, ir_FunSel=01, ir_LH=1, ir_enable=1; pc<=pc+1; -> DONE.
REQ-026 pc arithmetic SHALL be 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000.
REQ-027 Wait counter (8-bit) SHALL clear on entry to REQ_LO/REQ_HI and increment each cycle without mem_valid; reaching TIMEOUT -> ERR, pc unchanged for that byte.
REQ-028 DONE: done=1 for one cycle; -> IDLE. ERR: error=1 for one cycle; -> IDLE.
REQ-029 start and pc_load outside IDLE SHALL be ignored (not queued); mem_valid outside REQ_LO/REQ_HI SHALL be ignored.
REQ-030 When ir_enable=0, ir_I, ir_FunSel, ir_LH SHALL be driven 0.
REQ-031 Minimum fetch latency: start to done = 4 cycles with mem_valid in the first cycle of each REQ state.

Reset
REQ-032 On reset: state=IDLE, pc=0, wait counter=0; all outputs 0 on the following cycle.
REQ-033 Reset mid-fetch SHALL abandon the fetch with no ir_enable, done or error pulse; reset dominates start and pc_load.

Structure
REQ-034 Shared package SHALL hold the IR FunSel encodings (CLEAR=2'b00, LOAD=2'b01, DEC=2'b10, INC=2'b11) and the FSM state encoding.
REQ-035 The 16-bit pc with load/increment SHALL be one sub-module, pc_counter; the FSM and wait counter stay in ir_fetch_ctrl.

Verification
REQ-036 reset, pc_load with pc_in=16'h0100, start, mem_valid with 8'h34 then 8'h12 -> CLR pulse, LO load 34, HI load 12, done at cycle 4, pc=16'h0102; IR model holds 16'h1234.
REQ-037 start, mem_valid delayed 3 cycles per byte -> mem_req held, mem_addr stable, done at cycle 10, no error.
REQ-038 TIMEOUT=4, start, no mem_valid -> error pulse after 4 REQ_LO cycles, pc unchanged, no LO write, back to IDLE.
REQ-039 pc=16'hFFFF, full fetch -> addresses FFFF then 0000, final pc=16'h0001.
REQ-040 reset asserted in REQ_HI after LO load -> no HI write, no done, pc=0, busy=0; start and pc_load pulses while busy -> ignored.
